draw_scheduler: RTL and testbench

Sequences pixel writes into the 240×180 note playfield of the 320×240 VGA frame buffer and shares that single write path between two requesters: a playfield-clear source and a note-block draw source. It accepts one rectangle job at a time, steps through it one pixel per clock and drives x/y/colour/plot straight into the VGA adapter. It also adds the playfield origin offset, so requesters work in playfield-relative coordinates.

---
 rtl/draw_pkg.sv | 28 ++
 rtl/draw_scheduler_if.sv | 31 +++
 rtl/draw_scheduler_rect_scanner.sv | 53 +++++
 rtl/draw_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_draw_scheduler.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the draw scheduler slice.
//   state_e    - scheduler FSM encoding (IDLE -> LOAD -> SCAN -> DONE)
//   req_id_e   - identifies the two requesters sharing the VGA write path
//   FIELD_*    - default playfield placement inside the 320x240 frame
//   BLACK/WHITE - common colour codes
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_DONE
  } state_e;

  typedef enum logic {
    REQ_CLR,
    REQ_BLK
  } req_id_e;

  localparam int FIELD_X0_DEF = 0;
  localparam int FIELD_Y0_DEF = 60;
  localparam int FIELD_W_DEF  = 240;
  localparam int FIELD_H_DEF  = 180;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: request/grant handshake and VGA write bus.
//   master - requester side: drives clr_*/blk_* requests, sees acks, status, VGA bus
//   slave  - scheduler side: the reverse
interface draw_scheduler_if;
  logic       clr_req;
  logic [2:0] clr_colour;
  logic       blk_req;
  logic [7:0] blk_x;
  logic [7:0] blk_y;
  logic [7:0] blk_w;
  logic [7:0] blk_h;
  logic [2:0] blk_colour;
  logic       clr_ack;
  logic       blk_ack;
  logic       busy;
  logic       done;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output clr_req, clr_colour, blk_req, blk_x, blk_y, blk_w, blk_h, blk_colour,
    input  clr_ack, blk_ack, busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  clr_req, clr_colour, blk_req, blk_x, blk_y, blk_w, blk_h, blk_colour,
    output clr_ack, blk_ack, busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/draw_scheduler_rect_scanner.sv
// rect_scanner: row-major pixel counters for one rectangle job.
//   clock/resetn - clock, async active-low reset
//   load         - zero both counters
//   step         - advance one pixel (X inner, Y outer)
//   w, h         - rectangle size (only meaningful when non-zero)
//   cx, cy       - current pixel offset inside the rectangle
//   last         - current pixel is (w-1, h-1)
module rect_scanner (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] w,
  input  logic [7:0] h,
  output logic [7:0] cx,
  output logic [7:0] cy,
  output logic       last
);
  logic [7:0] cx_d, cx_q;
  logic [7:0] cy_d, cy_q;
  logic       row_end;

  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    row_end = (cx_q == w - 8'd1);
    if (load) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step) begin
      if (row_end) begin
        cx_d = '0;
        cy_d = cy_q + 8'd1;
      end else begin
        cx_d = cx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = row_end && (cy_q == h - 8'd1);
endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates a playfield-clear source and a note-block source
// onto the single VGA write path, scanning one rectangle job per grant at one
// pixel per clock and offsetting playfield-relative coordinates to screen.
//   clock/resetn - clock, async active-low reset
//   bus (slave)  - clr/blk requests, acks, busy/done, vga_x/y/colour/plot
// Build option: SCHED_FAIR_EN selects round-robin arbitration on a tie;
// otherwise clear has fixed priority over block.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int FIELD_X0 = FIELD_X0_DEF,
  parameter int FIELD_Y0 = FIELD_Y0_DEF,
  parameter int FIELD_W  = FIELD_W_DEF,
  parameter int FIELD_H  = FIELD_H_DEF
) (
  input logic             clock,
  input logic             resetn,
  draw_scheduler_if.slave bus
);
  state_e     state_d, state_q;
  req_id_e    winner_d, winner_q;
  logic [7:0] job_x_d, job_x_q, job_y_d, job_y_q;
  logic [7:0] job_w_d, job_w_q, job_h_d, job_h_q;
  logic [2:0] job_c_d, job_c_q;
  logic       clr_ack_d, clr_ack_q, blk_ack_d, blk_ack_q;
  logic       busy_d, busy_q, done_d, done_q;
  logic [8:0] vga_x_d, vga_x_q;
  logic [7:0] vga_y_d, vga_y_q;
  logic [2:0] vga_colour_d, vga_colour_q;
  logic       vga_plot_d, vga_plot_q;
  logic       last_px_d, last_px_q;

  logic       scan_load, scan_step, scan_last, emit, pick_clr;
  logic [7:0] cx, cy;
  logic [9:0] rx, ry;

  rect_scanner u_scanner (
    .clock (clock),
    .resetn(resetn),
    .load  (scan_load),
    .step  (scan_step),
    .w     (job_w_q),
    .h     (job_h_q),
    .cx    (cx),
    .cy    (cy),
    .last  (scan_last)
  );

  assign rx = 10'(job_x_q) + 10'(cx);
  assign ry = 10'(job_y_q) + 10'(cy);

  always_comb begin
`ifdef SCHED_FAIR_EN
    pick_clr = bus.clr_req && (!bus.blk_req || winner_q == REQ_BLK);
`else
    pick_clr = bus.clr_req;
`endif
    state_d      = state_q;
    winner_d     = winner_q;
    job_x_d      = job_x_q;
    job_y_d      = job_y_q;
    job_w_d      = job_w_q;
    job_h_d      = job_h_q;
    job_c_d      = job_c_q;
    clr_ack_d    = 1'b0;
    blk_ack_d    = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    last_px_d    = last_px_q;
    scan_load    = 1'b0;
    emit         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.clr_req || bus.blk_req) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
          // Counters are cleared on the grant edge so that LOAD can register
          // pixel (0,0) and the first plot lands in the cycle after LOAD.
          scan_load = 1'b1;
          if (pick_clr) begin
            job_x_d   = '0;
            job_y_d   = '0;
            job_w_d   = 8'(FIELD_W);
            job_h_d   = 8'(FIELD_H);
            job_c_d   = bus.clr_colour;
            clr_ack_d = 1'b1;
            winner_d  = REQ_CLR;
          end else begin
            job_x_d   = bus.blk_x;
            job_y_d   = bus.blk_y;
            job_w_d   = bus.blk_w;
            job_h_d   = bus.blk_h;
            job_c_d   = bus.blk_colour;
            blk_ack_d = 1'b1;
            winner_d  = REQ_BLK;
          end
        end
      end
      ST_LOAD: begin
        busy_d = 1'b1;
        if (job_w_q == '0 || job_h_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SCAN;
          emit    = 1'b1;
        end
      end
      ST_SCAN: begin
        busy_d = 1'b1;
        // last_px_q marks that the pixel now on the bus was the final one.
        if (last_px_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          emit = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    scan_step = emit;
    if (emit) begin
      vga_x_d      = 9'(10'(FIELD_X0) + rx);
      vga_y_d      = 8'(10'(FIELD_Y0) + ry);
      vga_colour_d = job_c_q;
      vga_plot_d   = (rx < 10'(FIELD_W)) && (ry < 10'(FIELD_H));
      last_px_d    = scan_last;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      winner_q     <= REQ_BLK;
      job_x_q      <= '0;
      job_y_q      <= '0;
      job_w_q      <= '0;
      job_h_q      <= '0;
      job_c_q      <= '0;
      clr_ack_q    <= 1'b0;
      blk_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      last_px_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      job_x_q      <= job_x_d;
      job_y_q      <= job_y_d;
      job_w_q      <= job_w_d;
      job_h_q      <= job_h_d;
      job_c_q      <= job_c_d;
      clr_ack_q    <= clr_ack_d;
      blk_ack_q    <= blk_ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      last_px_q    <= last_px_d;
    end
  end

  assign bus.clr_ack    = clr_ack_q;
  assign bus.blk_ack    = blk_ack_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: scoreboard bench for draw_scheduler with default
// playfield placement (X0=0, Y0=60, 240x180).
module tb_draw_scheduler;
  import draw_pkg::*;

  typedef struct packed {
    int         cyc;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } px_t;

  logic clock;
  logic resetn;
  int   cyc;
  int   n_checks;
  int   n_errors;
  px_t  sb[$];

  draw_scheduler_if bus ();

  draw_scheduler #(
    .FIELD_X0(0),
    .FIELD_Y0(60),
    .FIELD_W (240),
    .FIELD_H (180)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every plot is matched, in order and on its exact cycle, to the model queue.
  always @(negedge clock) begin
    if (resetn && bus.vga_plot) begin
      if (sb.size() == 0) begin
        check("extra_plot", 64'(sb.size()), 64'd1);
      end else begin
        px_t e, g;
        e = sb.pop_front();
        g = '{cyc: cyc, x: bus.vga_x, y: bus.vga_y, c: bus.vga_colour};
        check("pixel", 64'(g), 64'(e));
      end
    end
  end

  // Model: row-major scan, one cycle per pixel from a+1, clipped to 240x180.
  task automatic push_rect(input int a, input int x, input int y, input int w, input int h,
                           input logic [2:0] c);
    int idx;
    idx = 0;
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        if (x + i < 240 && y + j < 180)
          sb.push_back('{cyc: a + 1 + idx, x: 9'(x + i), y: 8'(60 + y + j), c: c});
        idx++;
      end
    end
  endtask

  task automatic set_blk(input int x, input int y, input int w, input int h, input logic [2:0] c);
    bus.blk_x      = 8'(x);
    bus.blk_y      = 8'(y);
    bus.blk_w      = 8'(w);
    bus.blk_h      = 8'(h);
    bus.blk_colour = c;
  endtask

  task automatic start_job(input bit want_clr, input bit want_blk, input bit exp_clr,
                           output int a);
    @(negedge clock);
    bus.clr_req = want_clr;
    bus.blk_req = want_blk;
    @(negedge clock);
    check("clr_ack", 64'(bus.clr_ack), 64'(exp_clr));
    check("blk_ack", 64'(bus.blk_ack), 64'(!exp_clr));
    check("busy_load", 64'(bus.busy), 64'd1);
    a = cyc;
    bus.clr_req = 1'b0;
    bus.blk_req = 1'b0;
  endtask

  task automatic finish_job(input int a, input int npx);
    int d;
    // Scramble inputs to show the job was latched at grant.
    bus.blk_x      = ~bus.blk_x;
    bus.blk_y      = ~bus.blk_y;
    bus.blk_w      = ~bus.blk_w;
    bus.blk_h      = ~bus.blk_h;
    bus.blk_colour = ~bus.blk_colour;
    bus.clr_colour = ~bus.clr_colour;
    @(negedge clock);
    check("ack_pulse", 64'(bus.clr_ack | bus.blk_ack), 64'd0);
    d = -1;
    for (int i = 0; i < npx + 8; i++) begin
      if (bus.done) begin
        d = cyc;
        break;
      end
      @(negedge clock);
    end
    check("done_cyc", 64'(d), 64'(a + 1 + npx));
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("busy_done", 64'(bus.busy), 64'd1);
    @(negedge clock);
    check("done_pulse", 64'(bus.done), 64'd0);
    check("busy_idle", 64'(bus.busy), 64'd0);
    check("plot_idle", 64'(bus.vga_plot), 64'd0);
  endtask

  task automatic run_blk(input int x, input int y, input int w, input int h, input logic [2:0] c);
    int a;
    set_blk(x, y, w, h, c);
    start_job(1'b0, 1'b1, 1'b0, a);
    push_rect(a, x, y, w, h, c);
    finish_job(a, w * h);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, 64'(bus.vga_x), 64'd0);
    check({tag, "_y"}, 64'(bus.vga_y), 64'd0);
    check({tag, "_colour"}, 64'(bus.vga_colour), 64'd0);
    check({tag, "_plot"}, 64'(bus.vga_plot), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_acks"}, 64'({bus.clr_ack, bus.blk_ack}), 64'd0);
  endtask

  initial begin
    int  a;
    bit  exp_clr2;
    n_checks       = 0;
    n_errors       = 0;
    resetn         = 1'b0;
    bus.clr_req    = 1'b0;
    bus.blk_req    = 1'b0;
    bus.clr_colour = BLACK;
    set_blk(0, 0, 0, 0, BLACK);
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clock);
    check_reset_outputs("post_reset");

    // Basic 2x2 block.
    run_blk(10, 5, 2, 2, 3'b100);
    // Zero-size jobs: no plots, done one cycle after ack.
    run_blk(20, 20, 0, 5, WHITE);
    run_blk(20, 20, 5, 0, WHITE);
    // Right-edge and bottom-edge clipping.
    run_blk(238, 0, 4, 1, 3'b010);
    run_blk(100, 178, 3, 3, 3'b011);

    // Tie 1: clear wins under either arbitration mode; full playfield clear.
    bus.clr_colour = BLACK;
    set_blk(1, 1, 1, 1, WHITE);
    start_job(1'b1, 1'b1, 1'b1, a);
    push_rect(a, 0, 0, 240, 180, BLACK);
    finish_job(a, 43200);

    // Tie 2: fair mode rotates to block; fixed priority keeps clear.
`ifdef SCHED_FAIR_EN
    exp_clr2 = 1'b0;
`else
    exp_clr2 = 1'b1;
`endif
    bus.clr_colour = 3'b001;
    set_blk(30, 40, 20, 20, 3'b110);
    start_job(1'b1, 1'b1, exp_clr2, a);
    if (exp_clr2) push_rect(a, 0, 0, 240, 180, 3'b001);
    else          push_rect(a, 30, 40, 20, 20, 3'b110);

    // Abort that job mid-scan with reset.
    repeat (50) @(negedge clock);
    check("mid_scan_busy", 64'(bus.busy), 64'd1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("abort");
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort_no_done", 64'(bus.done), 64'd0);
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("idle_no_done", 64'(bus.done), 64'd0);
      check("idle_no_plot", 64'(bus.vga_plot), 64'd0);
    end

    // Normal job after the abort.
    run_blk(0, 0, 3, 2, 3'b101);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
